// File: rtl/ctrl_pkg.sv
// Shared encodings for the instruction-sequencing controller: states, opcodes,
// jump conditions, error causes and ALU select bit positions.
package ctrl_pkg;

   typedef enum logic [5:0] {
      S_IDLE      = 6'b000001,
      S_FETCH     = 6'b000010,
      S_DECODE    = 6'b000100,
      S_EXECUTE   = 6'b001000,
      S_INCREMENT = 6'b010000,
      S_HALT      = 6'b100000
   } state_t;

   localparam logic [3:0] OP_LOAD = 4'b0000;
   localparam logic [3:0] OP_AND  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_JMP  = 4'b1000;
   localparam logic [3:0] OP_JCC  = 4'b1001;
   localparam logic [3:0] OP_IN   = 4'b1010;
   localparam logic [3:0] OP_OUT  = 4'b1110;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam logic [1:0] CC_Z  = 2'b00;
   localparam logic [1:0] CC_NZ = 2'b01;
   localparam logic [1:0] CC_C  = 2'b10;
   localparam logic [1:0] CC_NC = 2'b11;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   localparam int ALU_B0 = 0;
   localparam int ALU_B1 = 1;
   localparam int ALU_B2 = 2;
   localparam int ALU_B3 = 3;
   localparam int ALU_B4 = 4;

   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         OP_LOAD, OP_AND, OP_ADD, OP_SUB, OP_JMP,
         OP_JCC, OP_IN, OP_OUT, OP_HALT: op_legal = 1'b1;
         default:                        op_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request waits for its acknowledge; flags expiry on
// the cycle the count sits at all-ones and the request is still unanswered.
module mem_wait_timer #(
   parameter int TMO_W = 4
) (
   input  logic clk,
   input  logic clr,
   input  logic clear,
   input  logic run,
   output logic expired
);

   logic [TMO_W-1:0] count;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (run) begin
         count <= count + 1'b1;
      end
   end

   assign expired = run && (&count);

endmodule

// File: rtl/ctrl_fsm.sv
// Fetch/decode/execute/increment controller for a small accumulator datapath.
// Outputs are decoded from the one-hot state, the latched opcode and flags.
module ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int TMO_W  = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic [DATA_W-1:0] ir,
   input  logic              carry,
   input  logic              zero,
   input  logic              mem_ack,
   output logic              mem_req,
   output logic              rw,
   output logic [4:0]        alu,
   output logic              muxa,
   output logic              muxb,
   output logic              muxc,
   output logic              en_ir,
   output logic              en_da,
   output logic              en_pc,
   output logic              halted,
   output logic [1:0]        err,
   output state_t            state
);

   // Memory handshake: mem_req stays high for the whole access; the cycle in
   // which mem_ack is sampled high completes it, and the request drops after.
   logic [3:0] op_q;
   logic [1:0] cond_q;
   logic       carry_q, zero_q;
   logic [3:0] op;
   logic       is_load, is_and, is_add, is_sub, is_jmp, is_jcc, is_in, is_out;
   logic       mem_op, alu_op, cond_true, taken;
   logic       in_de, in_inc, exec_final, expired;
   logic       unused_ir_bits;

   assign unused_ir_bits = ^ir[DATA_W-7:0];

   // DECODE sees the freshly loaded instruction; later states use the copy.
   assign op = (state == S_DECODE) ? ir[DATA_W-1 -: 4] : op_q;

   assign is_load = (op == OP_LOAD);
   assign is_and  = (op == OP_AND);
   assign is_add  = (op == OP_ADD);
   assign is_sub  = (op == OP_SUB);
   assign is_jmp  = (op == OP_JMP);
   assign is_jcc  = (op == OP_JCC);
   assign is_in   = (op == OP_IN);
   assign is_out  = (op == OP_OUT);
   assign mem_op  = is_load | is_in | is_out;
   assign alu_op  = is_add | is_sub | is_and;

   always_comb begin
      cond_true = 1'b0;
      case (cond_q)
         CC_Z:    cond_true = zero_q;
         CC_NZ:   cond_true = ~zero_q;
         CC_C:    cond_true = carry_q;
         CC_NC:   cond_true = ~carry_q;
         default: cond_true = 1'b0;
      endcase
   end

   assign taken      = is_jmp | (is_jcc & cond_true);
   assign in_de      = (state == S_DECODE) || (state == S_EXECUTE);
   assign in_inc     = (state == S_INCREMENT);
   assign exec_final = (state == S_EXECUTE) && (!mem_op || mem_ack);

   mem_wait_timer #(.TMO_W(TMO_W)) u_timer (
      .clk     (clk),
      .clr     (clr),
      .clear   (~mem_req),
      .run     (mem_req & ~mem_ack),
      .expired (expired)
   );

   // HALT is left only through clr, so the single err write per run is the
   // first cause.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state   <= S_IDLE;
         op_q    <= OP_LOAD;
         cond_q  <= CC_Z;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         err     <= ERR_NONE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) state <= S_FETCH;
            end
            S_FETCH: begin
               if (mem_ack) begin
                  state <= S_DECODE;
               end else if (expired) begin
                  state <= S_HALT;
                  err   <= ERR_TIMEOUT;
               end
            end
            S_DECODE: begin
               op_q   <= ir[DATA_W-1 -: 4];
               cond_q <= ir[DATA_W-5 -: 2];
               if (!op_legal(op)) begin
                  state <= S_HALT;
                  err   <= ERR_ILLEGAL;
               end else if (op == OP_HALT) begin
                  state <= S_HALT;
               end else begin
                  state <= S_EXECUTE;
               end
            end
            S_EXECUTE: begin
               if (exec_final) begin
                  state <= S_INCREMENT;
                  if (alu_op) begin
                     carry_q <= carry;
                     zero_q  <= zero;
                  end
               end else if (expired) begin
                  state <= S_HALT;
                  err   <= ERR_TIMEOUT;
               end
            end
            S_INCREMENT: state <= S_FETCH;
            S_HALT:      state <= S_HALT;
            default:     state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      mem_req     = (state == S_FETCH) || ((state == S_EXECUTE) && mem_op);
      rw          = (state == S_EXECUTE) && is_out;
      en_ir       = (state == S_FETCH) && mem_ack;
      en_da       = exec_final && (is_load || alu_op || is_in);
      en_pc       = (exec_final && taken) || (in_inc && !taken);
      alu         = '0;
      alu[ALU_B0] = in_de && (is_and || is_in || is_load || is_jmp || is_jcc);
      alu[ALU_B1] = in_de && (is_out || is_in || is_load || is_jmp || is_jcc);
      alu[ALU_B2] = (in_de && is_sub) || in_inc;
      alu[ALU_B3] = in_de && is_sub;
      alu[ALU_B4] = in_inc;
      muxa        = in_inc;
      muxb        = in_de && (is_load || alu_op);
      muxc        = in_de && (is_in || is_out);
      halted      = (state == S_HALT);
   end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm: an instruction-level model emits the expected
// output word for every cycle; a negedge process compares the DUT against it.
module tb_ctrl_fsm;

  localparam int DATA_W  = 8;
  localparam int TMO_W   = 4;
  localparam int TMO_CYC = 1 << TMO_W;

  localparam logic [3:0] B_LOAD = 4'b0000, B_AND = 4'b0001, B_ADD = 4'b0100;
  localparam logic [3:0] B_SUB  = 4'b0110, B_JMP = 4'b1000, B_JCC = 4'b1001;
  localparam logic [3:0] B_IN   = 4'b1010, B_OUT = 4'b1110, B_HALT = 4'b1111;
  localparam logic [3:0] B_ILL  = 4'b0010;
  localparam logic [5:0] ST_IDLE = 6'b000001, ST_INC = 6'b010000, ST_HALT = 6'b100000;

  logic clk = 1'b0;
  logic clr, start, carry, zero, mem_ack;
  logic [DATA_W-1:0] ir;
  logic mem_req, rw, muxa, muxb, muxc, en_ir, en_da, en_pc, halted;
  logic [4:0] alu;
  logic [1:0] err;
  logic [5:0] state;
  logic [15:0] obs;

  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] exp_q[$];
  string name_q[$];
  longint t_ir[$];
  int n_da = 0;

  logic m_c, m_z;
  logic [1:0] m_err;

  always #5 clk = ~clk;

  ctrl_fsm #(.DATA_W(DATA_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .clr(clr), .start(start), .ir(ir), .carry(carry), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .rw(rw), .alu(alu), .muxa(muxa),
    .muxb(muxb), .muxc(muxc), .en_ir(en_ir), .en_da(en_da), .en_pc(en_pc),
    .halted(halted), .err(err), .state(state)
  );

  assign obs = {mem_req, rw, alu, muxa, muxb, muxc, en_ir, en_da, en_pc, halted, err};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endtask

  // ---- model: expectations built from the instruction-level rules ----
  function automatic logic [15:0] vec(input logic mreq, input logic rwv, input logic [4:0] a,
                                      input logic ma, input logic mb, input logic mc,
                                      input logic ei, input logic ed, input logic ep,
                                      input logic h, input logic [1:0] e);
    return {mreq, rwv, a, ma, mb, mc, ei, ed, ep, h, e};
  endfunction

  // {alu[4:0], muxb, muxc} while an opcode is in DECODE or EXECUTE
  function automatic logic [6:0] de_tab(input logic [3:0] op);
    case (op)
      B_LOAD:  return 7'b00011_10;
      B_AND:   return 7'b00001_10;
      B_ADD:   return 7'b00000_10;
      B_SUB:   return 7'b01100_10;
      B_JMP:   return 7'b00011_00;
      B_JCC:   return 7'b00011_00;
      B_IN:    return 7'b00011_01;
      B_OUT:   return 7'b00010_01;
      default: return 7'b00000_00;
    endcase
  endfunction

  function automatic bit is_mem(input logic [3:0] op);
    return op == B_LOAD || op == B_IN || op == B_OUT;
  endfunction
  function automatic bit is_alu(input logic [3:0] op);
    return op == B_ADD || op == B_SUB || op == B_AND;
  endfunction
  function automatic bit writes_da(input logic [3:0] op);
    return is_alu(op) || op == B_LOAD || op == B_IN;
  endfunction
  function automatic bit legal(input logic [3:0] op);
    return is_mem(op) || is_alu(op) || op == B_JMP || op == B_JCC || op == B_HALT;
  endfunction
  function automatic bit jump_taken(input logic [3:0] op, input logic [1:0] cond);
    bit c;
    c = (cond == 2'd0) ? m_z : (cond == 2'd1) ? !m_z : (cond == 2'd2) ? m_c : !m_c;
    return op == B_JMP || (op == B_JCC && c);
  endfunction

  function automatic logic [15:0] fetch_v(input logic ack);
    return vec(1, 0, 5'b0, 0, 0, 0, ack, 0, 0, 0, 2'b00);
  endfunction
  function automatic logic [15:0] dec_v(input logic [3:0] op);
    logic [6:0] t;
    t = de_tab(op);
    return vec(0, 0, t[6:2], 0, t[1], t[0], 0, 0, 0, 0, 2'b00);
  endfunction
  function automatic logic [15:0] exec_v(input logic [3:0] op, input bit fin, input bit tk);
    logic [6:0] t;
    t = de_tab(op);
    return vec(is_mem(op), op == B_OUT, t[6:2], 0, t[1], t[0], 0,
               fin && writes_da(op), fin && tk, 0, 2'b00);
  endfunction
  function automatic logic [15:0] inc_v(input bit tk);
    return vec(0, 0, 5'b10100, 1, 0, 0, 0, 0, !tk, 0, 2'b00);
  endfunction
  function automatic logic [15:0] halt_v();
    return vec(0, 0, 5'b0, 0, 0, 0, 0, 0, 0, 1, m_err);
  endfunction

  // ---- driver ----
  task automatic step(input logic ack, input logic c, input logic z,
                      input logic [15:0] e, input string nm);
    @(posedge clk);
    #1;
    mem_ack = ack;
    carry   = c;
    zero    = z;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic do_instr(input logic [3:0] op, input logic [1:0] cond, input int fwait,
                          input int ewait, input logic c, input logic z);
    bit tk;
    ir = {op, cond, 2'b00};
    for (int i = 0; i < fwait && i < TMO_CYC; i++) step(0, 0, 0, fetch_v(0), "fetch_wait");
    if (fwait >= TMO_CYC) begin
      if (m_err == 2'b00) m_err = 2'b10;
      return;
    end
    step(1, 0, 0, fetch_v(1), "fetch_ack");
    step(0, 0, 0, dec_v(op), "decode");
    if (!legal(op)) begin
      if (m_err == 2'b00) m_err = 2'b01;
      return;
    end
    if (op == B_HALT) return;
    tk = jump_taken(op, cond);
    if (is_mem(op)) begin
      for (int i = 0; i < ewait && i < TMO_CYC; i++) step(0, c, z, exec_v(op, 0, tk), "exec_wait");
      if (ewait >= TMO_CYC) begin
        if (m_err == 2'b00) m_err = 2'b10;
        return;
      end
    end
    step(is_mem(op), c, z, exec_v(op, 1, tk), "exec_final");
    if (is_alu(op)) begin
      m_c = c;
      m_z = z;
    end
    step(0, 0, 0, inc_v(tk), "increment");
  endtask

  task automatic halt_steps(input int n);
    for (int i = 0; i < n; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, halt_v(), "halt_hold");
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    clr = 1; start = 1; mem_ack = 1; carry = 1; zero = 1; ir = 8'h40;
    #1;
    check("reset_async_outputs", 32'(obs), 32'h0);
    check("reset_async_state", 32'(state), 32'(ST_IDLE));
    @(posedge clk);
    #2;
    check("reset_hold_outputs", 32'(obs), 32'h0);
    check("reset_hold_state", 32'(state), 32'(ST_IDLE));
    m_c = 0; m_z = 0; m_err = 2'b00;
    start = 0; mem_ack = 0; carry = 0; zero = 0;
    @(negedge clk);
    clr = 0;
  endtask

  task automatic begin_run();
    step(0, 0, 0, 16'h0, "idle_no_start");
    step(0, 0, 0, 16'h0, "idle_start");
    start = 1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // ---- compare process and monitors ----
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin : cmp
      logic [15:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, 32'(obs), 32'(e));
    end
    if (en_ir) t_ir.push_back(longint'($time));
    if (en_da) n_da++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    clr = 0; start = 0; carry = 0; zero = 0; mem_ack = 0; ir = '0;
    m_c = 0; m_z = 0; m_err = 2'b00;
    do_reset();

    // two ADDs with immediate acks: four-cycle instruction period
    begin_run();
    t_ir.delete();
    do_instr(B_ADD, 2'b00, 0, 0, 0, 0);
    #2;
    check("pin_add_inc_state", 32'(state), 32'(ST_INC));
    check("pin_add_inc_alu", 32'(alu), 32'h14);
    check("pin_add_inc_en_pc", 32'(en_pc), 32'h1);
    do_instr(B_ADD, 2'b00, 0, 0, 0, 0);
    settle();
    if (t_ir.size() >= 2) check("pin_period", 32'(t_ir[1] - t_ir[0]), 32'd40);
    else check("pin_period_samples", 32'(t_ir.size()), 32'd2);

    // flags then conditional jumps on the registered flags
    do_instr(B_ADD, 2'b00, 1, 0, 1, 0);
    do_instr(B_JCC, 2'b11, 0, 0, 0, 0);
    do_instr(B_JCC, 2'b10, 0, 0, 0, 0);
    do_instr(B_JCC, 2'b00, 0, 0, 0, 0);
    do_instr(B_JCC, 2'b01, 2, 0, 0, 0);
    do_instr(B_SUB, 2'b00, 0, 0, 0, 1);
    do_instr(B_JCC, 2'b00, 0, 0, 0, 0);
    do_instr(B_AND, 2'b00, 0, 0, 1, 1);
    do_instr(B_LOAD, 2'b00, 1, 1, 0, 0);
    do_instr(B_OUT, 2'b00, 0, 2, 0, 0);
    do_instr(B_JMP, 2'b00, 0, 0, 0, 0);

    // IN waiting three cycles for its ack
    settle();
    n_da = 0;
    do_instr(B_IN, 2'b00, 0, 3, 0, 0);
    settle();
    check("pin_in_en_da_pulses", 32'(n_da), 32'd1);

    do_instr(B_HALT, 2'b00, 0, 0, 0, 0);
    halt_steps(3);

    // fetch timeout
    do_reset();
    begin_run();
    do_instr(B_ADD, 2'b00, TMO_CYC, 0, 0, 0);
    halt_steps(4);
    #2;
    check("pin_timeout_err", 32'(err), 32'h2);
    check("pin_timeout_halted", 32'(halted), 32'h1);

    // illegal opcode
    do_reset();
    begin_run();
    settle();
    n_da = 0;
    do_instr(B_ILL, 2'b00, 0, 0, 0, 0);
    halt_steps(3);
    settle();
    check("pin_illegal_err", 32'(err), 32'h1);
    check("pin_illegal_state", 32'(state), 32'(ST_HALT));
    check("pin_illegal_no_en_da", 32'(n_da), 32'd0);

    // execute-phase timeout on OUT
    do_reset();
    begin_run();
    do_instr(B_OUT, 2'b00, 0, TMO_CYC, 0, 0);
    halt_steps(2);

    // clr during an EXECUTE wait, then flags must read as cleared
    do_reset();
    begin_run();
    do_instr(B_ADD, 2'b00, 0, 0, 1, 1);
    ir = {B_IN, 4'b0000};
    step(1, 0, 0, fetch_v(1), "fetch_ack");
    step(0, 0, 0, dec_v(B_IN), "decode");
    step(0, 0, 0, exec_v(B_IN, 0, 0), "exec_wait");
    step(0, 0, 0, exec_v(B_IN, 0, 0), "exec_wait");
    do_reset();
    begin_run();
    do_instr(B_JCC, 2'b10, 0, 0, 0, 0);
    do_instr(B_JCC, 2'b01, 0, 0, 0, 0);
    do_instr(B_IN, 2'b00, 0, 1, 0, 0);

    settle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 Parameters: DATA_W, default 8, instruction width (>=8); TMO_W, default 4, memory-wait timeout counter width.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 clr  in  1  asynchronous active-high reset.
REQ-005 start  in  1  level; leaves IDLE when high.
REQ-006 ir  in  DATA_W  instruction; opcode=ir[DATA_W-1:DATA_W-4], cond=ir[DATA_W-5:DATA_W-6].
REQ-007 carry, zero  in  1 each  ALU flags, valid in EXECUTE.
REQ-008 mem_ack  in  1  memory completion for the current mem_req.
REQ-009 mem_req  out  1  memory access in progress.
REQ-010 rw  out  1  1=write (OUT), 0=read.
REQ-011 alu  out  5  ALU operation select.
REQ-012 muxa, muxb, muxc  out  1 each  datapath mux selects.
REQ-013 en_ir, en_da, en_pc  out  1 each  register load enables.
REQ-014 halted  out  1  high in HALT state.
REQ-015 err  out  2  sticky cause: 01 illegal opcode, 10 memory timeout.

Function
REQ-016 States IDLE, FETCH, DECODE, EXECUTE, INCREMENT, HALT; one-hot encoded.
REQ-017 Transitions: IDLE->FETCH when start=1. FETCH->DECODE on mem_ack. DECODE->EXECUTE, or DECODE->HALT for HALT or illegal opcode. EXECUTE->INCREMENT when no memory op, or on mem_ack. INCREMENT->FETCH. HALT is held until clr.
REQ-018 Opcodes: LOAD 0000, AND 0001, ADD 0100, SUB 0110, JMP 1000, JCC 1001, IN 1010, OUT 1110, HALT 1111. All other opcodes are illegal.
REQ-019 JCC conditions: cond 00=Z, 01=NZ, 10=C, 11=NC. NC tests ~carry_reg.
REQ-020 mem_req=1 throughout FETCH, and throughout EXECUTE for LOAD, IN and OUT.
REQ-021 rw=1 only in EXECUTE for OUT.
REQ-022 en_ir=1 only in the FETCH cycle that has mem_ack=1.
REQ-023 Timeout counter:
- cleared on entry to each mem_req state;
- increments every cycle while mem_req=1 and mem_ack=0;
- at all-ones without ack: err=10, state->HALT next cycle.
REQ-024 carry_reg and zero_reg latch carry and zero in the final EXECUTE cycle of ADD, SUB or AND only.
REQ-025 jump taken = JMP, or JCC with its condition true on the registered flags.
REQ-026 en_pc timing:
- taken jump: high in the final EXECUTE cycle only;
- all other instructions: high in INCREMENT;
- never high in both.
REQ-027 en_da=1 in the final EXECUTE cycle of LOAD, ADD, SUB, AND and IN.
REQ-028 alu bits, each asserted in DECODE and EXECUTE:
- alu[0]: AND, IN, LOAD, JMP, JCC;
- alu[1]: OUT, IN, LOAD, JMP, JCC;
- alu[3]: SUB.
REQ-029 alu[2] is asserted for SUB (in DECODE and EXECUTE) and in INCREMENT. alu[4] and muxa are asserted only in INCREMENT.
REQ-030 muxb=1 for LOAD, ADD, SUB and AND. muxc=1 for IN and OUT. Both apply in DECODE and EXECUTE.
REQ-031 Outputs are combinational from state, registered ir decode and flags. In IDLE and HALT all enables, mem_req and rw are 0.
REQ-032 err is written only on entry to HALT. The first cause wins.

Reset
REQ-033 clr=1 forces, asynchronously:
- state=IDLE;
- carry_reg=0, zero_reg=0;
- timeout counter=0;
- err=00, halted=0.
REQ-034 With clr=1, all outputs are 0, including mid-fetch or mid-wait. No enable may pulse during reset.
REQ-035 After clr falls, the first FETCH starts on the first edge where start=1.

Structure
REQ-036 A shared package ctrl_pkg holds:
- state encodings;
- opcode and cond constants;
- err codes;
- alu bit positions.
REQ-037 The timeout counter is the sub-module mem_wait_timer (ports: clk, clr, clear, run, expired).

Verification
REQ-038 Reset then start=1, ir=0x4x (ADD), mem_ack tied 1 -> state period 4 cycles. en_da is 1 in EXECUTE and en_pc is 1 in INCREMENT.
REQ-039 ADD producing carry=1, zero=0, then JCC cond=11 (NC) -> not taken: en_pc in INCREMENT only. Repeat with cond=10 (C) -> en_pc in EXECUTE only.
REQ-040 IN with mem_ack delayed 3 cycles -> mem_req held 4 cycles in EXECUTE and en_da pulses once, in the ack cycle.
REQ-041 FETCH with mem_ack=0 for 16 cycles (TMO_W=4) -> err=10, halted=1, all enables 0 thereafter.
REQ-042 ir=0x2x (illegal) -> HALT directly from DECODE, err=01, no en_da or en_pc pulse.
REQ-043 Assert clr during an EXECUTE wait -> state=IDLE immediately, all outputs 0, flags 0, then a normal restart.
